// File: rtl/hilo_mult_unit_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply unit.
interface hilo_mult_unit_if;
   logic        Start;
   logic [5:0]  ALUControl;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic        Done;
   logic [31:0] Result;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output Start, ALUControl, A, B,
      input  Busy, Done, Result, HI, LO
   );

   modport slave (
      input  Start, ALUControl, A, B,
      output Busy, Done, Result, HI, LO
   );
endinterface

// File: rtl/hilo_mult_unit.sv
// Iterative sign-magnitude multiply/accumulate unit owning the HI/LO registers.
// Retires RADIX_BITS multiplier bits per ITER cycle, then a FINISH cycle commits.
module hilo_mult_unit #(
   parameter int unsigned RADIX_BITS = 1
) (
   input logic              Clk,
   input logic              Reset,
   hilo_mult_unit_if.slave  bus
);
   localparam int unsigned N     = 32 / RADIX_BITS;
   localparam int unsigned CNT_W = $clog2(N);

   localparam logic [5:0] OP_MULT  = 6'd3;
   localparam logic [5:0] OP_MULTU = 6'd4;
   localparam logic [5:0] OP_MUL   = 6'd19;
   localparam logic [5:0] OP_MADD  = 6'd20;
   localparam logic [5:0] OP_MSUB  = 6'd21;
   localparam logic [5:0] OP_MFHI  = 6'd23;
   localparam logic [5:0] OP_MFLO  = 6'd24;
   localparam logic [5:0] OP_MTHI  = 6'd25;
   localparam logic [5:0] OP_MTLO  = 6'd26;

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FINISH} state_e;

   state_e             state_q, state_d;
   logic [5:0]         op_q, op_d;
   logic [63:0]        mcand_q, mcand_d;
   logic [31:0]        mplier_q, mplier_d;
   logic [63:0]        prod_q, prod_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic [31:0]        res_q, res_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               is_mul;
   logic               is_signed;
   logic [31:0]        abs_a;
   logic [31:0]        abs_b;
   logic [63:0]        p_fin;
   logic [63:0]        hilo_acc;

   // Next-state and datapath for the whole unit.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      prod_d    = prod_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      res_d     = res_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      is_mul    = (bus.ALUControl == OP_MULT) || (bus.ALUControl == OP_MULTU) ||
                  (bus.ALUControl == OP_MUL)  || (bus.ALUControl == OP_MADD)  ||
                  (bus.ALUControl == OP_MSUB);
      is_signed = is_mul && (bus.ALUControl != OP_MULTU);
      abs_a     = (is_signed && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
      abs_b     = (is_signed && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;
      p_fin     = neg_q ? (~prod_q + 64'd1) : prod_q;
      hilo_acc  = {hi_q, lo_q};

      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               if (is_mul) begin
                  op_d     = bus.ALUControl;
                  mcand_d  = 64'(abs_a);
                  mplier_d = abs_b;
                  neg_d    = is_signed && (bus.A[31] ^ bus.B[31]);
                  prod_d   = 64'd0;
                  cnt_d    = '0;
                  busy_d   = 1'b1;
                  state_d  = S_ITER;
               end else begin
                  case (bus.ALUControl)
                     OP_MTHI: begin hi_d = bus.A; done_d = 1'b1; end
                     OP_MTLO: begin lo_d = bus.A; done_d = 1'b1; end
                     OP_MFHI: begin res_d = hi_q; done_d = 1'b1; end
                     OP_MFLO: begin res_d = lo_q; done_d = 1'b1; end
                     default: ;
                  endcase
               end
            end
         end
         S_ITER: begin
            prod_d   = prod_q + mcand_q * 64'(mplier_q[RADIX_BITS-1:0]);
            mcand_d  = mcand_q << RADIX_BITS;
            mplier_d = mplier_q >> RADIX_BITS;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) state_d = S_FINISH;
         end
         S_FINISH: begin
            // MADD/MSUB wrap modulo 2^64 through plain 64-bit add/sub.
            case (op_q)
               OP_MADD: hilo_acc = hilo_acc + p_fin;
               OP_MSUB: hilo_acc = hilo_acc - p_fin;
               default: hilo_acc = p_fin;
            endcase
            if (op_q == OP_MUL) begin
               res_d = p_fin[31:0];
            end else begin
               hi_d = hilo_acc[63:32];
               lo_d = hilo_acc[31:0];
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         op_q     <= 6'd0;
         mcand_q  <= 64'd0;
         mplier_q <= 32'd0;
         prod_q   <= 64'd0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         res_q    <= 32'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_q    <= res_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.Busy   = busy_q;
   assign bus.Done   = done_q;
   assign bus.Result = res_q;
   assign bus.HI     = hi_q;
   assign bus.LO     = lo_q;
endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench: directed test-plan sequences plus random traffic against
// an instruction-level model of HI/LO, Result, Busy and Done.
module tb_hilo_mult_unit;
   localparam int unsigned RADIX_BITS = 1;
   localparam int unsigned N          = 32 / RADIX_BITS;

   localparam logic [5:0] OP_MULT  = 6'd3;
   localparam logic [5:0] OP_MULTU = 6'd4;
   localparam logic [5:0] OP_MUL   = 6'd19;
   localparam logic [5:0] OP_MADD  = 6'd20;
   localparam logic [5:0] OP_MSUB  = 6'd21;
   localparam logic [5:0] OP_MFHI  = 6'd23;
   localparam logic [5:0] OP_MFLO  = 6'd24;
   localparam logic [5:0] OP_MTHI  = 6'd25;
   localparam logic [5:0] OP_MTLO  = 6'd26;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;
   int   n_chk = 0;
   int   n_bad = 0;

   hilo_mult_unit_if bus();

   hilo_mult_unit #(.RADIX_BITS(RADIX_BITS)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Full 64-bit product from the instruction's definition.
   function automatic logic [63:0] product(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa;
      longint sb;
      if (op == OP_MULTU) return {32'd0, a} * {32'd0, b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
   endfunction

   // Inputs as seen at the rising edge.
   logic        c_reset = 1'b1;
   logic        c_start = 1'b0;
   logic [5:0]  c_op    = 6'd0;
   logic [31:0] c_a     = 32'd0;
   logic [31:0] c_b     = 32'd0;

   always @(posedge Clk) begin
      c_reset <= Reset;
      c_start <= bus.Start;
      c_op    <= bus.ALUControl;
      c_a     <= bus.A;
      c_b     <= bus.B;
   end

   // Instruction-level model: an accepted multiply occupies N+1 cycles, then commits.
   logic [31:0] e_hi = 32'd0, e_lo = 32'd0, e_res = 32'd0;
   logic        e_busy = 1'b0, e_done = 1'b0;
   int          rem = 0;
   logic [5:0]  p_op = 6'd0;
   logic [63:0] p_val = 64'd0;

   always @(negedge Clk) begin
      logic [63:0] acc;
      if (c_reset) begin
         e_hi = 32'd0; e_lo = 32'd0; e_res = 32'd0;
         e_busy = 1'b0; e_done = 1'b0; rem = 0;
      end else begin
         e_done = 1'b0;
         if (rem > 0) begin
            rem--;
            if (rem == 0) begin
               acc = {e_hi, e_lo};
               case (p_op)
                  OP_MUL:  e_res = p_val[31:0];
                  OP_MADD: acc = acc + p_val;
                  OP_MSUB: acc = acc - p_val;
                  default: acc = p_val;
               endcase
               {e_hi, e_lo} = acc;
               e_busy = 1'b0;
               e_done = 1'b1;
            end
         end else if (c_start) begin
            case (c_op)
               OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB: begin
                  p_op   = c_op;
                  p_val  = product(c_op, c_a, c_b);
                  rem    = N + 1;
                  e_busy = 1'b1;
               end
               OP_MTHI: begin e_hi  = c_a;  e_done = 1'b1; end
               OP_MTLO: begin e_lo  = c_a;  e_done = 1'b1; end
               OP_MFHI: begin e_res = e_hi; e_done = 1'b1; end
               OP_MFLO: begin e_res = e_lo; e_done = 1'b1; end
               default: ;
            endcase
         end
      end
      chk("busy",   32'(bus.Busy), 32'(e_busy));
      chk("done",   32'(bus.Done), 32'(e_done));
      chk("hi",     bus.HI,        e_hi);
      chk("lo",     bus.LO,        e_lo);
      chk("result", bus.Result,    e_res);
   end

   // Issue one instruction at a falling edge and wait (bounded) for Done; returns Busy count.
   task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cyc);
      int k;
      bus.Start = 1'b1; bus.ALUControl = op; bus.A = a; bus.B = b;
      @(negedge Clk);
      bus.Start = 1'b0;
      busy_cyc = 0;
      k = 0;
      while (!bus.Done && k < 100) begin
         if (bus.Busy) busy_cyc++;
         @(negedge Clk);
         k++;
      end
      n_chk++;
      if (!bus.Done) begin
         n_bad++;
         $display("FAIL done_timeout: op=%0d no Done within %0d cycles", op, k);
      end
   endtask

   function automatic logic [31:0] rnd32();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   logic [5:0] op_tab [12] = '{OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB, OP_MFHI,
                              OP_MFLO, OP_MTHI, OP_MTLO, 6'd0, 6'd5, 6'd63};

   initial begin
      int bc;
      bus.Start = 1'b0; bus.ALUControl = 6'd0; bus.A = 32'd0; bus.B = 32'd0;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      chk("rst_hi", bus.HI, 32'd0);
      chk("rst_result", bus.Result, 32'd0);

      do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, bc);
      chk("mult_busy_cycles", 32'(bc), 32'd33);
      chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
      chk("mult_lo", bus.LO, 32'hFFFF_FFEB);
      @(negedge Clk);
      chk("done_one_cycle", 32'(bus.Done), 32'd0);

      do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
      chk("multu_hi", bus.HI, 32'hFFFF_FFFE);
      chk("multu_lo", bus.LO, 32'h0000_0001);
      do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, bc);
      chk("mult_min_hi", bus.HI, 32'h4000_0000);
      chk("mult_min_lo", bus.LO, 32'd0);

      do_op(OP_MTHI, 32'd0, 32'd0, bc);
      do_op(OP_MTLO, 32'd10, 32'd0, bc);
      do_op(OP_MADD, 32'd5, 32'd2, bc);
      chk("madd_hi", bus.HI, 32'd0);
      chk("madd_lo", bus.LO, 32'd20);
      do_op(OP_MSUB, 32'd4, 32'd8, bc);
      chk("msub_hi", bus.HI, 32'hFFFF_FFFF);
      chk("msub_lo", bus.LO, 32'hFFFF_FFF4);
      do_op(OP_MFLO, 32'd0, 32'd0, bc);
      chk("mflo_result", bus.Result, 32'hFFFF_FFF4);
      chk("mflo_no_busy", 32'(bc), 32'd0);

      do_op(OP_MUL, 32'h0001_0001, 32'h0001_0001, bc);
      chk("mul_result", bus.Result, 32'h0002_0001);
      chk("mul_hi_kept", bus.HI, 32'hFFFF_FFFF);
      chk("mul_lo_kept", bus.LO, 32'hFFFF_FFF4);

      // MTLO arriving mid-multiply must be dropped.
      bus.Start = 1'b1; bus.ALUControl = OP_MULT; bus.A = 32'd6; bus.B = 32'd7;
      @(negedge Clk);
      bus.Start = 1'b0;
      repeat (4) @(negedge Clk);
      bus.Start = 1'b1; bus.ALUControl = OP_MTLO; bus.A = 32'h55;
      @(negedge Clk);
      bus.Start = 1'b0;
      repeat (40) begin
         if (!bus.Done) @(negedge Clk);
      end
      chk("ignored_lo", bus.LO, 32'd42);
      chk("ignored_hi", bus.HI, 32'd0);

      // Reset mid-multiply discards the operation.
      @(negedge Clk);
      bus.Start = 1'b1; bus.ALUControl = OP_MULT; bus.A = 32'd6; bus.B = 32'd7;
      @(negedge Clk);
      bus.Start = 1'b0;
      repeat (9) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      chk("rst_mid_busy", 32'(bus.Busy), 32'd0);
      chk("rst_mid_lo", bus.LO, 32'd0);
      chk("rst_mid_res", bus.Result, 32'd0);
      repeat (30) @(negedge Clk);
      do_op(OP_MULT, 32'd2, 32'd3, bc);
      chk("after_rst_lo", bus.LO, 32'd6);

      // Random traffic, including Start while busy, illegal codes and occasional reset.
      for (int i = 0; i < 4000; i++) begin
         bus.Start      = ($urandom_range(0, 2) == 0);
         bus.ALUControl = op_tab[$urandom_range(0, 11)];
         bus.A          = rnd32();
         bus.B          = rnd32();
         Reset          = ($urandom_range(0, 299) == 0);
         @(negedge Clk);
      end
      bus.Start = 1'b0;
      Reset     = 1'b0;
      repeat (40) @(negedge Clk);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- Multi-cycle multiply/accumulate unit with architectural HI/LO registers.
- Sits in the execute stage beside the single-cycle ALU and consumes the same 6-bit ALUControl code from the ALU controller.
- Handles MULT, MULTU, MUL, MADD, MSUB, MFHI, MFLO, MTHI and MTLO.
- Signals Busy so the pipeline stalls while a multiply is in flight.

Parameters:
- RADIX_BITS, 1, multiplier bits retired per iteration cycle; legal values 1, 2, 4. N = 32/RADIX_BITS.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request qualifier; ALUControl, A and B are sampled only when Start=1.
- ALUControl  input  6  operation code: MULT=3, MULTU=4, MUL=19, MADD=20, MSUB=21, MFHI=23, MFLO=24, MTHI=25, MTLO=26.
- A  input  32  operand rs.
- B  input  32  operand rt.
- Busy  output  1  unit is occupied; new Start is ignored.
- Done  output  1  one-cycle pulse when an operation completes.
- Result  output  32  registered GPR write-back value (MUL, MFHI, MFLO).
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset (synchronous, active-high):
  - HI, LO, Result = 0; Busy = 0; Done = 0; FSM = IDLE.
  - Applies even mid-multiply; the in-flight operation is discarded with no HI/LO update.
- FSM states: IDLE, ITER, FINISH.
- IDLE, Start=1 with MULT/MULTU/MUL/MADD/MSUB:
  - Latch op, capture |A| and |B| (signed ops) or raw A and B (MULTU).
  - Latch product sign = A[31]^B[31] for signed ops, else 0.
  - Clear 64-bit partial product, clear iteration counter, go to ITER, Busy=1.
- IDLE, Start=1 with MTHI/MTLO:
  - HI<=A (MTHI) or LO<=A (MTLO) at that edge.
  - Done=1 the next cycle; Busy stays 0.
- IDLE, Start=1 with MFHI/MFLO:
  - Result<=HI or LO at that edge; Done=1 next cycle.
  - Value is HI/LO as of before the edge.
- IDLE, Start=1 with any other code: ignored; no state change, no Done.
- ITER:
  - Each cycle, shift-add RADIX_BITS multiplier bits (unsigned) into the partial product.
  - After N cycles go to FINISH.
- FINISH (one cycle):
  - Apply two's-complement negation if sign is set, giving 64-bit P.
  - MULT/MULTU: {HI,LO}<=P.
  - MADD: {HI,LO}<={HI,LO}+P, modulo 2^64.
  - MSUB: {HI,LO}<={HI,LO}-P, modulo 2^64.
  - MUL: Result<=P[31:0]; HI/LO unchanged.
  - Go to IDLE, Busy<=0, Done<=1 for exactly one cycle.
- Latency and Busy timing:
  - Start sampled at edge t gives Busy=1 from after edge t until after edge t+N+1.
  - Done=1 in the cycle after edge t+N+1 (33 cycles for RADIX_BITS=1).
- Start while Busy=1: ignored entirely; the upstream stall logic must hold the instruction.
- Back-to-back: Start may be asserted in the Done cycle and is accepted.
  - MFHI/MFLO issued there sees the just-written HI/LO.
- Result holds its value until the next MUL/MFHI/MFLO completion.
- HI/LO change only at MTHI/MTLO edges, FINISH, or Reset.
- Signed edge cases: -2^31 magnitude is 0x80000000 in the unsigned path and must produce correct results.
- Done is never asserted together with Busy.

Test Plan:
- Reset, then MULT A=0xFFFFFFFD (-3), B=7 -> Busy for 33 cycles; Done pulse one cycle; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. MULT A=B=0x80000000 -> HI=0x40000000, LO=0.
- MTHI 0, MTLO 10; MADD 5,2 -> HI=0, LO=20; MSUB 4,8 -> HI=0xFFFFFFFF, LO=0xFFFFFFF4. MFLO -> Result=0xFFFFFFF4, Done one cycle after Start.
- MUL A=B=0x00010001 -> Result=0x00020001 after 33 cycles; HI/LO unchanged from prior values.
- MULT 6,7 in flight; assert Start with MTLO 0x55 at cycle 5 -> ignored; final LO=42, HI=0.
- MULT 6,7; Reset at cycle 10 -> next cycle Busy=0, HI=LO=Result=0, no Done. A subsequent MULT 2,3 completes normally with LO=6.
